pcie_cfg_apb_arb: RTL



---
 rtl/pcie_cfg_apb_arb.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pcie_cfg_apb_arb.sv
// Round-robin arbiter serialising requester word accesses onto one APB3 master port.
// Optional macro CFG_ARB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT cycles without pready_i.
module pcie_cfg_apb_arb #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*32-1:0]     req_wdata_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic [31:0]               pwdata_o,
  input  logic                      pready_i,
  input  logic                      pslverr_i,
  input  logic [31:0]               prdata_i
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e              state_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     id_q;
  logic [NUM_REQ-1:0]  req_ready_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_err_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [31:0]         pwdata_q;

  logic                found_d;
  logic [ID_W-1:0]     win_d;
  logic                sel_write_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [31:0]         sel_wdata_d;

`ifdef CFG_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    tmo_q;
`endif

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] ptr, input int off);
    int s;
    s = int'(ptr) + off;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return s[ID_W-1:0];
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] oh;
    for (int k = 0; k < NUM_REQ; k++) begin
      oh[k] = (ID_W'(k) == id);
    end
    return oh;
  endfunction

  // Round-robin winner: scan from rr_ptr_q upwards, the nearest valid requester wins.
  always_comb begin
    found_d = |req_valid_i;
    win_d   = rr_ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      win_d = req_valid_i[rr_idx(rr_ptr_q, i)] ? rr_idx(rr_ptr_q, i) : win_d;
    end
  end

  // Select the winning requester's command fields.
  always_comb begin
    sel_write_d = 1'b0;
    sel_addr_d  = '0;
    sel_wdata_d = 32'h0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_write_d = (ID_W'(k) == win_d) ? req_write_i[k]                 : sel_write_d;
      sel_addr_d  = (ID_W'(k) == win_d) ? req_addr_i[k*ADDR_W +: ADDR_W] : sel_addr_d;
      sel_wdata_d = (ID_W'(k) == win_d) ? req_wdata_i[k*32 +: 32]        : sel_wdata_d;
    end
  end

  // Arbitration/APB FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= 32'h0;
`ifdef CFG_ARB_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            req_ready_q <= onehot(win_d);
            id_q        <= win_d;
            rr_ptr_q    <= rr_idx(win_d, 1);
            pwrite_q    <= sel_write_d;
            paddr_q     <= sel_addr_d;
            pwdata_q    <= sel_wdata_d;
            // Misaligned words never reach the slave; they are answered with an error.
            state_q     <= (sel_addr_d[1:0] != 2'b00) ? RESP : SETUP;
          end else begin
            state_q <= IDLE;
          end
        end
        SETUP: begin
          psel_q    <= 1'b1;
          penable_q <= 1'b0;
`ifdef CFG_ARB_TIMEOUT_EN
          tmo_q     <= '0;
`endif
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (!penable_q) begin
            penable_q <= 1'b1;
          end else if (pready_i) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= onehot(id_q);
            rsp_rdata_q <= pwrite_q ? 32'h0 : prdata_i;
            rsp_err_q   <= pslverr_i;
            state_q     <= IDLE;
          end
`ifdef CFG_ARB_TIMEOUT_EN
          else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= onehot(id_q);
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b1;
            state_q     <= IDLE;
          end else begin
            tmo_q <= tmo_q + CNT_W'(1);
          end
`else
          else begin
            state_q <= ACCESS;
          end
`endif
        end
        RESP: begin
          rsp_valid_q <= onehot(id_q);
          rsp_rdata_q <= 32'h0;
          rsp_err_q   <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;

endmodule
